multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports `clk` and `rst`.
REQ-002 The block SHALL have these parameters:
- `TIMEOUT`, default 15: max wait cycles for `mem_ready` per access.
- `AOPW`, default 3: width of `aop`.
REQ-003 The block SHALL have these ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  async active-high reset.
- `opa`  in  6  opcode from the instruction register; stable from DECODE until the next FETCH.
- `func`  in  6  R-type function field; same stability as `opa`.
- `zf`  in  1  ALU zero flag; sampled in EXEC.
- `mem_ready`  in  1  memory access complete this cycle.
- `state`  out  3  current FSM state code.
- `ir_we`, `pc_we`, `mem_req`, `mem_we`, `wea`  out  1 each  IR load, PC load, memory request, memory write, regfile write.
- `wrs`, `wrds`, `pcs`  out  2 each  write-reg select, write-data select, PC source.
- `imms`, `rims`  out  1 each  sign-extend immediate, ALU B = immediate.
- `aop`  out  AOPW  ALU operation.
- `busy`  out  1  high in every state except TRAP.
- `illegal`  out  1  sticky, unsupported opcode/func.
- `timeout_err`  out  1  sticky, memory wait exceeded.

Function
REQ-004 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-005 All outputs SHALL be combinational from `state`, `opa`, `func`, `zf`, `mem_ready` and the two sticky flags. Every strobe not named for a state SHALL be 0.
REQ-006 FETCH:
- `mem_req`=1.
- On `mem_ready`: `ir_we`=1, `pc_we`=1, `pcs`=00 (PC+4), go to DECODE.
- Otherwise stay.
REQ-007 DECODE:
- Unsupported `opa`, or `opa`=000000 with unsupported `func`: go to TRAP and set `illegal`.
- j (000010): `pc_we`=1, `pcs`=11, go to FETCH.
- jal (000011): `pc_we`=1, `pcs`=11, `wea`=1, `wrs`=10 (r31), `wrds`=10 (PC), go to FETCH.
- All others: go to EXEC.
REQ-008 EXEC, ALU field map:
- R-type `func`→`aop`: 100000→100, 100010→101, 100100→000, 100101→001, 100110→010, 100111→011, 101011→110, 000100→111.
- addi/lw/sw: `aop`=100, `rims`=1, `imms`=1.
- andi/xori/sltiu (001100/001110/001011): `aop`=000/010/110, `rims`=1, `imms`=0.
REQ-009 EXEC, next state:
- R-type ALU and I-type ALU: go to WB.
- lw/sw: go to MEM.
- jr (`func`=001000): `pc_we`=1, `pcs`=01, go to FETCH.
- beq/bne: `aop`=101; `pc_we` = `zf` (beq) or ~`zf` (bne); `pcs`=10; go to FETCH.
REQ-010 MEM:
- `mem_req`=1; `mem_we`=1 for sw only; stay until `mem_ready`.
- On `mem_ready`: lw goes to WB, sw goes to FETCH.
REQ-011 WB:
- `wea`=1.
- `wrs`=00 (rd) for R-type, 01 (rt) for I-type and lw.
- `wrds`=01 for lw, 00 otherwise.
- Go to FETCH.
REQ-012 Wait counter:
- Width $clog2(TIMEOUT+1); clears on every state change.
- Increments each FETCH/MEM cycle with `mem_ready`=0.
- When it equals TIMEOUT and `mem_ready`=0: go to TRAP, set `timeout_err`, no strobes that cycle.
- `mem_ready`=1 on the TIMEOUT-th cycle completes normally.
REQ-013 TRAP SHALL hold until reset, with all strobes 0 and `busy`=0.
REQ-014 With zero-wait memory, latencies SHALL be, in cycles:
- R-type/I-type: 4.
- lw: 5.
- sw: 4.
- beq/bne/jr: 3.
- j/jal: 2.

Reset
REQ-015 While `rst`=1:
- `state` SHALL be FETCH; the counter, `illegal` and `timeout_err` SHALL be 0.
- All strobes (`ir_we`, `pc_we`, `mem_req`, `mem_we`, `wea`) SHALL be forced to 0.
REQ-016 Reset asserted mid-instruction SHALL abort it with no further write strobe; the first `mem_req` SHALL be in the first cycle after deassertion.

Structure
REQ-017 A shared package SHALL hold the state encoding, opcode/func constants, `aop` encodings and the `pcs`/`wrs`/`wrds` encodings.
REQ-018 One combinational sub-module `mc_decode` SHALL map `opa`/`func` to:
- instruction class (RTYPE, ITYPE, LOAD, STORE, BRANCH, JUMP, JAL, JR, ILLEGAL);
- static `aop`/`imms`/`rims`.
The FSM SHALL live in `multicycle_control`.

Verification
REQ-019 add (`opa`=000000, `func`=100000), `mem_ready`=1 → states 0,1,2,4,0; `aop`=100 in EXEC; `wea`=1 with `wrs`=00 in WB only.
REQ-020 lw (100011), `mem_ready` low 3 cycles in MEM → MEM lasts 4 cycles, then WB with `wrds`=01, `wrs`=01; total 8 cycles.
REQ-021 beq (000100): `zf`=1 → `pc_we`=1, `pcs`=10 in EXEC; `zf`=0 → `pc_we`=0; bne inverse; each 3 cycles.
REQ-022 jal (000011) → `pc_we`=1, `wea`=1, `wrs`=10, `wrds`=10 in DECODE; back to FETCH in 2 cycles.
REQ-023 `opa`=111111 → TRAP after DECODE; `illegal`=1, `busy`=0; remains in TRAP until `rst`.
REQ-024 `mem_ready`=0 for 16 FETCH cycles (TIMEOUT=15) → TRAP with `timeout_err`=1; `rst` pulse mid-MEM of sw → `mem_we`=0 immediately, FETCH after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multicycle controller: FSM state encoding,
// decoded instruction classes, opcode/func field values, ALU operation codes
// and the select encodings for PC source, write register and write data.
package multicycle_control_pkg;

    // FSM states; the numeric codes are visible on the state output
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_ITYPE,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_JAL,
        CL_JR,
        CL_ILLEGAL
    } iclass_t;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function field values
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] AOP_AND  = 3'b000;
    localparam logic [2:0] AOP_OR   = 3'b001;
    localparam logic [2:0] AOP_XOR  = 3'b010;
    localparam logic [2:0] AOP_NOR  = 3'b011;
    localparam logic [2:0] AOP_ADD  = 3'b100;
    localparam logic [2:0] AOP_SUB  = 3'b101;
    localparam logic [2:0] AOP_SLTU = 3'b110;
    localparam logic [2:0] AOP_SLLV = 3'b111;

    // PC source select
    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_JR  = 2'b01;
    localparam logic [1:0] PCS_BR  = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    // Register-file write register select
    localparam logic [1:0] WRS_RD  = 2'b00;
    localparam logic [1:0] WRS_RT  = 2'b01;
    localparam logic [1:0] WRS_R31 = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WRDS_ALU = 2'b00;
    localparam logic [1:0] WRDS_MEM = 2'b01;
    localparam logic [1:0] WRDS_PC  = 2'b10;

endpackage

// File: rtl/multicycle_control_decode.sv
// mc_decode
// Purely combinational instruction decoder for the multicycle controller.
// Ports:
//   opa    in  6  opcode field
//   func   in  6  R-type function field
//   iclass out    instruction class
//   aop    out 3  static ALU operation for this instruction
//   imms   out 1  sign-extend immediate
//   rims   out 1  ALU B operand is the immediate
//   br_ne  out 1  branch taken on "not equal" (bne) rather than equal (beq)
module mc_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opa,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic [2:0] aop,
    output logic       imms,
    output logic       rims,
    output logic       br_ne
);

    // Anything not explicitly recognised falls through to CL_ILLEGAL
    always_comb begin
        iclass = CL_ILLEGAL;
        aop    = AOP_AND;
        imms   = 1'b0;
        rims   = 1'b0;
        br_ne  = 1'b0;
        case (opa)
            OP_RTYPE: begin
                iclass = CL_RTYPE;
                case (func)
                    FN_ADD:  aop = AOP_ADD;
                    FN_SUB:  aop = AOP_SUB;
                    FN_AND:  aop = AOP_AND;
                    FN_OR:   aop = AOP_OR;
                    FN_XOR:  aop = AOP_XOR;
                    FN_NOR:  aop = AOP_NOR;
                    FN_SLTU: aop = AOP_SLTU;
                    FN_SLLV: aop = AOP_SLLV;
                    FN_JR:   iclass = CL_JR;
                    default: iclass = CL_ILLEGAL;
                endcase
            end
            OP_J:   iclass = CL_JUMP;
            OP_JAL: iclass = CL_JAL;
            OP_BEQ: begin
                iclass = CL_BRANCH;
                aop    = AOP_SUB;
            end
            OP_BNE: begin
                iclass = CL_BRANCH;
                aop    = AOP_SUB;
                br_ne  = 1'b1;
            end
            OP_ADDI: begin
                iclass = CL_ITYPE;
                aop    = AOP_ADD;
                rims   = 1'b1;
                imms   = 1'b1;
            end
            OP_ANDI: begin
                iclass = CL_ITYPE;
                aop    = AOP_AND;
                rims   = 1'b1;
            end
            OP_XORI: begin
                iclass = CL_ITYPE;
                aop    = AOP_XOR;
                rims   = 1'b1;
            end
            OP_SLTIU: begin
                iclass = CL_ITYPE;
                aop    = AOP_SLTU;
                rims   = 1'b1;
            end
            OP_LW: begin
                iclass = CL_LOAD;
                aop    = AOP_ADD;
                rims   = 1'b1;
                imms   = 1'b1;
            end
            OP_SW: begin
                iclass = CL_STORE;
                aop    = AOP_ADD;
                rims   = 1'b1;
                imms   = 1'b1;
            end
            default: iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for a multicycle MIPS-like datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB, waits on mem_ready with a bounded wait counter,
// and parks in TRAP on an illegal instruction or a memory timeout.
// Ports:
//   clk, rst               clock, async active-high reset
//   opa, func, zf          instruction fields and ALU zero flag
//   mem_ready              memory access completes this cycle
//   state                  current FSM state code
//   ir_we, pc_we           IR load, PC load
//   mem_req, mem_we        memory request, memory write
//   wea                    register-file write
//   wrs, wrds, pcs         write-reg, write-data and PC source selects
//   imms, rims, aop        immediate sign-extend, ALU B = imm, ALU op
//   busy                   low only in TRAP
//   illegal, timeout_err   sticky error flags
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int AOPW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opa,
    input  logic [5:0]      func,
    input  logic            zf,
    input  logic            mem_ready,
    output logic [2:0]      state,
    output logic            ir_we,
    output logic            pc_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            wea,
    output logic [1:0]      wrs,
    output logic [1:0]      wrds,
    output logic [1:0]      pcs,
    output logic            imms,
    output logic            rims,
    output logic [AOPW-1:0] aop,
    output logic            busy,
    output logic            illegal,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    iclass_t            iclass;
    logic [2:0]         dec_aop;
    logic               br_ne;
    logic               timed_out;

    mc_decode u_decode (
        .opa    (opa),
        .func   (func),
        .iclass (iclass),
        .aop    (dec_aop),
        .imms   (imms),
        .rims   (rims),
        .br_ne  (br_ne)
    );

    // A wait that has already spent TIMEOUT cycles and still sees no
    // mem_ready gives up this cycle; mem_ready on that cycle still wins.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT)) && !mem_ready;

    // Next-state and strobe logic. Strobes are combinational so that a
    // mem_ready completion and the associated load happen in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        wea       = 1'b0;
        wrs       = WRS_RD;
        wrds      = WRDS_ALU;
        pcs       = PCS_PC4;

        case (state_q)
            S_FETCH: begin
                if (timed_out) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pcs     = PCS_PC4;
                        state_d = S_DECODE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                case (iclass)
                    CL_ILLEGAL: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                    CL_JUMP: begin
                        pc_we   = 1'b1;
                        pcs     = PCS_JMP;
                        state_d = S_FETCH;
                    end
                    CL_JAL: begin
                        pc_we   = 1'b1;
                        pcs     = PCS_JMP;
                        wea     = 1'b1;
                        wrs     = WRS_R31;
                        wrds    = WRDS_PC;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    CL_RTYPE, CL_ITYPE: state_d = S_WB;
                    CL_LOAD, CL_STORE:  state_d = S_MEM;
                    CL_JR: begin
                        pc_we   = 1'b1;
                        pcs     = PCS_JR;
                        state_d = S_FETCH;
                    end
                    CL_BRANCH: begin
                        pc_we   = br_ne ? ~zf : zf;
                        pcs     = PCS_BR;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (timed_out) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (iclass == CL_STORE);
                    if (mem_ready) begin
                        state_d = (iclass == CL_LOAD) ? S_WB : S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WB: begin
                wea     = 1'b1;
                wrs     = (iclass == CL_RTYPE) ? WRS_RD : WRS_RT;
                wrds    = (iclass == CL_LOAD) ? WRDS_MEM : WRDS_ALU;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // The wait counter measures time spent in one state only
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Reset kills every strobe at once, even mid-instruction
        if (rst) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            wea     = 1'b0;
        end
    end

    // State, wait counter and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign aop         = AOPW'(dec_aop);
    assign busy        = (state_q != S_TRAP);
    assign illegal     = illegal_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed testbench for multicycle_control. Inputs change just after the
// falling clock edge and outputs are compared before the next rising edge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opa;
    logic [5:0] func;
    logic       zf;
    logic       memReady;
    logic [2:0] state;
    logic       irWe, pcWe, memReq, memWe, wea;
    logic [1:0] wrs, wrds, pcs;
    logic       imms, rims;
    logic [2:0] aop;
    logic       busy, illegal, timeoutErr;

    int checkCount = 0;
    int errorCount = 0;

    multicycle_control #(.TIMEOUT(15), .AOPW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .opa         (opa),
        .func        (func),
        .zf          (zf),
        .mem_ready   (memReady),
        .state       (state),
        .ir_we       (irWe),
        .pc_we       (pcWe),
        .mem_req     (memReq),
        .mem_we      (memWe),
        .wea         (wea),
        .wrs         (wrs),
        .wrds        (wrds),
        .pcs         (pcs),
        .imms        (imms),
        .rims        (rims),
        .aop         (aop),
        .busy        (busy),
        .illegal     (illegal),
        .timeout_err (timeoutErr)
    );

    always #5 clk = ~clk;

    // Single point of comparison: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive instruction inputs and let the combinational outputs settle
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic ready);
        opa      = op;
        func     = fn;
        zf       = z;
        memReady = ready;
        #1;
    endtask

    // Advance one clock and land just after the falling edge
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        cycle();
        rst = 1'b0;
        #1;
    endtask

    // Watchdog: the directed sequence is a few hundred cycles at most
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
        cycle();

        // Reset state, strobes forced low even though FETCH would request
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_memreq", 32'(memReq), 32'd0);
        checkOutput("rst_irwe", 32'(irWe), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_timeout", 32'(timeoutErr), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_memreq", 32'(memReq), 32'd1);

        // add: 0,1,2,4,0
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        checkOutput("add_f_state", 32'(state), 32'd0);
        checkOutput("add_f_irwe", 32'(irWe), 32'd1);
        checkOutput("add_f_pcwe", 32'(pcWe), 32'd1);
        checkOutput("add_f_pcs", 32'(pcs), 32'd0);
        checkOutput("add_f_wea", 32'(wea), 32'd0);
        cycle();
        checkOutput("add_d_state", 32'(state), 32'd1);
        checkOutput("add_d_wea", 32'(wea), 32'd0);
        checkOutput("add_d_pcwe", 32'(pcWe), 32'd0);
        cycle();
        checkOutput("add_e_state", 32'(state), 32'd2);
        checkOutput("add_e_aop", 32'(aop), 32'b100);
        checkOutput("add_e_wea", 32'(wea), 32'd0);
        cycle();
        checkOutput("add_w_state", 32'(state), 32'd4);
        checkOutput("add_w_wea", 32'(wea), 32'd1);
        checkOutput("add_w_wrs", 32'(wrs), 32'b00);
        checkOutput("add_w_wrds", 32'(wrds), 32'b00);
        cycle();
        checkOutput("add_end_state", 32'(state), 32'd0);

        // andi: zero-extended immediate, writes rt
        applyStimulus(6'b001100, 6'b000000, 1'b0, 1'b1);
        cycle();
        cycle();
        checkOutput("andi_e_aop", 32'(aop), 32'b000);
        checkOutput("andi_e_imms", 32'(imms), 32'd0);
        checkOutput("andi_e_rims", 32'(rims), 32'd1);
        cycle();
        checkOutput("andi_w_state", 32'(state), 32'd4);
        checkOutput("andi_w_wrs", 32'(wrs), 32'b01);
        cycle();
        checkOutput("andi_end_state", 32'(state), 32'd0);

        // lw with three wait cycles in MEM: 8 cycles total
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        cycle();
        checkOutput("lw_d_state", 32'(state), 32'd1);
        cycle();
        checkOutput("lw_e_state", 32'(state), 32'd2);
        checkOutput("lw_e_aop", 32'(aop), 32'b100);
        checkOutput("lw_e_imms", 32'(imms), 32'd1);
        checkOutput("lw_e_rims", 32'(rims), 32'd1);
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lw_m%0d_state", i), 32'(state), 32'd3);
            checkOutput($sformatf("lw_m%0d_memreq", i), 32'(memReq), 32'd1);
            checkOutput($sformatf("lw_m%0d_memwe", i), 32'(memWe), 32'd0);
            cycle();
        end
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        checkOutput("lw_m3_state", 32'(state), 32'd3);
        cycle();
        checkOutput("lw_w_state", 32'(state), 32'd4);
        checkOutput("lw_w_wea", 32'(wea), 32'd1);
        checkOutput("lw_w_wrs", 32'(wrs), 32'b01);
        checkOutput("lw_w_wrds", 32'(wrds), 32'b01);
        cycle();
        checkOutput("lw_end_state", 32'(state), 32'd0);

        // sw with zero-wait memory: back in FETCH after 4 cycles
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        cycle();
        cycle();
        cycle();
        checkOutput("sw_m_state", 32'(state), 32'd3);
        checkOutput("sw_m_memwe", 32'(memWe), 32'd1);
        cycle();
        checkOutput("sw_end_state", 32'(state), 32'd0);

        // beq/bne with both zero-flag values
        begin
            logic [5:0] brOp [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
            logic       brZf [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            logic       brPc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(brOp[i], 6'b000000, brZf[i], 1'b1);
                cycle();
                cycle();
                checkOutput($sformatf("br%0d_e_state", i), 32'(state), 32'd2);
                checkOutput($sformatf("br%0d_e_pcwe", i), 32'(pcWe), 32'(brPc[i]));
                checkOutput($sformatf("br%0d_e_pcs", i), 32'(pcs), 32'b10);
                checkOutput($sformatf("br%0d_e_aop", i), 32'(aop), 32'b101);
                cycle();
                checkOutput($sformatf("br%0d_end_state", i), 32'(state), 32'd0);
            end
        end

        // jr: PC from register in EXEC
        applyStimulus(6'b000000, 6'b001000, 1'b0, 1'b1);
        cycle();
        cycle();
        checkOutput("jr_e_pcwe", 32'(pcWe), 32'd1);
        checkOutput("jr_e_pcs", 32'(pcs), 32'b01);
        checkOutput("jr_e_wea", 32'(wea), 32'd0);
        cycle();
        checkOutput("jr_end_state", 32'(state), 32'd0);

        // jal: link and jump in DECODE
        applyStimulus(6'b000011, 6'b000000, 1'b0, 1'b1);
        cycle();
        checkOutput("jal_d_pcwe", 32'(pcWe), 32'd1);
        checkOutput("jal_d_pcs", 32'(pcs), 32'b11);
        checkOutput("jal_d_wea", 32'(wea), 32'd1);
        checkOutput("jal_d_wrs", 32'(wrs), 32'b10);
        checkOutput("jal_d_wrds", 32'(wrds), 32'b10);
        cycle();
        checkOutput("jal_end_state", 32'(state), 32'd0);

        // j: jump without a register write
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        cycle();
        checkOutput("j_d_pcwe", 32'(pcWe), 32'd1);
        checkOutput("j_d_pcs", 32'(pcs), 32'b11);
        checkOutput("j_d_wea", 32'(wea), 32'd0);
        cycle();
        checkOutput("j_end_state", 32'(state), 32'd0);

        // Reset in the middle of an sw memory wait
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        cycle();
        cycle();
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0);
        cycle();
        checkOutput("swr_m_memwe", 32'(memWe), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("swr_rst_memwe", 32'(memWe), 32'd0);
        checkOutput("swr_rst_memreq", 32'(memReq), 32'd0);
        checkOutput("swr_rst_state", 32'(state), 32'd0);
        cycle();
        rst = 1'b0;
        #1;
        checkOutput("swr_rel_state", 32'(state), 32'd0);
        checkOutput("swr_rel_memreq", 32'(memReq), 32'd1);

        // Illegal opcode: TRAP after DECODE, held until reset
        applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
        cycle();
        checkOutput("ill_d_state", 32'(state), 32'd1);
        checkOutput("ill_d_pcwe", 32'(pcWe), 32'd0);
        cycle();
        checkOutput("ill_t_state", 32'(state), 32'd5);
        checkOutput("ill_t_illegal", 32'(illegal), 32'd1);
        checkOutput("ill_t_busy", 32'(busy), 32'd0);
        checkOutput("ill_t_memreq", 32'(memReq), 32'd0);
        cycle();
        cycle();
        cycle();
        checkOutput("ill_hold_state", 32'(state), 32'd5);
        checkOutput("ill_hold_illegal", 32'(illegal), 32'd1);
        doReset();
        checkOutput("ill_rst_illegal", 32'(illegal), 32'd0);
        checkOutput("ill_rst_busy", 32'(busy), 32'd1);

        // Illegal R-type function
        applyStimulus(6'b000000, 6'b111111, 1'b0, 1'b1);
        cycle();
        cycle();
        checkOutput("illfn_state", 32'(state), 32'd5);
        checkOutput("illfn_illegal", 32'(illegal), 32'd1);
        doReset();

        // mem_ready arriving on the last allowed wait cycle completes normally
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("late_w%0d_memreq", i), 32'(memReq), 32'd1);
            cycle();
        end
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
        checkOutput("late_irwe", 32'(irWe), 32'd1);
        cycle();
        checkOutput("late_d_state", 32'(state), 32'd1);
        checkOutput("late_timeout", 32'(timeoutErr), 32'd0);
        cycle();
        cycle();
        cycle();
        checkOutput("late_end_state", 32'(state), 32'd0);

        // 16 FETCH cycles without mem_ready: timeout trap
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("to_w%0d_state", i), 32'(state), 32'd0);
            cycle();
        end
        checkOutput("to_last_state", 32'(state), 32'd0);
        checkOutput("to_last_memreq", 32'(memReq), 32'd0);
        checkOutput("to_last_irwe", 32'(irWe), 32'd0);
        cycle();
        checkOutput("to_t_state", 32'(state), 32'd5);
        checkOutput("to_t_timeout", 32'(timeoutErr), 32'd1);
        checkOutput("to_t_busy", 32'(busy), 32'd0);
        checkOutput("to_t_illegal", 32'(illegal), 32'd0);
        doReset();
        checkOutput("to_rst_timeout", 32'(timeoutErr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
